// File: rtl/riscy_pkg.sv
// Shared definitions for the integer decode/operand-fetch slice:
// datapath width, opcode/funct encodings and the decoded-operation record.
package riscy_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Decoded operation as held in the output register. The source indices
   // and the rs2_is_reg flag let a stalled operation pick up late writebacks;
   // they are zero whenever the operand did not come from the register file.
   typedef struct packed {
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [2:0]      funct3;
      logic            funct7;
      logic [4:0]      rd;
      logic            illegal;
      logic [4:0]      rs1_src;
      logic [4:0]      rs2_src;
      logic            rs2_is_reg;
   } dec_op_t;

endpackage

// File: rtl/id_stage_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// x0 reads as zero and ignores writes; a read of the register being written
// in the same cycle returns the incoming write data (write-first).
module regfile
   import riscy_pkg::*;
#(
   parameter int W = XLEN,
   parameter int N = NREG
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [$clog2(N)-1:0] waddr,
   input  logic [W-1:0]         wdata,
   input  logic [$clog2(N)-1:0] raddr1,
   input  logic [$clog2(N)-1:0] raddr2,
   output logic [W-1:0]         rdata1,
   output logic [W-1:0]         rdata2
);

   logic [W-1:0] regs_reg [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign regs_reg[gi] = '0;
         end else begin : g_store
            // One storage register; cleared on reset, written when addressed.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  regs_reg[gi] <= '0;
               else if (we && (waddr == gi[$clog2(N)-1:0]))
                  regs_reg[gi] <= wdata;
            end
         end
      end
   endgenerate

   // Read ports with write-first forwarding; index 0 is always zero.
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0)
         rdata1 = (we && waddr == raddr1) ? wdata : regs_reg[raddr1];
      if (raddr2 != '0)
         rdata2 = (we && waddr == raddr2) ? wdata : regs_reg[raddr2];
   end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-fetch stage for OP and OP-IMM integer instructions.
// Reads operands from the integrated register file (with writeback bypass)
// and holds the decoded operation in a one-entry valid/ready output register.
module id_stage
   import riscy_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rs1,
   output logic [XLEN-1:0] out_rs2,
   output logic [2:0]      out_funct3,
   output logic            out_funct7,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;
   logic            accept;
   logic            shift_imm;

   dec_op_t dec;
   dec_op_t op_reg;
   dec_op_t op_next;
   logic    valid_reg;
   logic    valid_next;

   assign opcode  = in_instr[6:0];
   assign f3      = in_instr[14:12];
   assign f7      = in_instr[31:25];
   assign rs1_idx = in_instr[19:15];
   assign rs2_idx = in_instr[24:20];

   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready;
   assign shift_imm = (f3 == F3_SLL) || (f3 == F3_SR);

   regfile #(.W(XLEN), .N(NREG)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr1 (rs1_idx),
      .raddr2 (rs2_idx),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   // Decode the incoming instruction; unsupported encodings zero everything
   // except rd and raise illegal.
   always_comb begin
      dec         = '0;
      dec.rd      = in_instr[11:7];
      dec.illegal = 1'b1;
      if (opcode == OPC_OP) begin
         if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) begin
            dec.illegal    = 1'b0;
            dec.rs1        = rdata1;
            dec.rs2        = rdata2;
            dec.funct3     = f3;
            dec.funct7     = in_instr[30];
            dec.rs1_src    = rs1_idx;
            dec.rs2_src    = rs2_idx;
            dec.rs2_is_reg = (rs2_idx != 5'd0);
         end
      end else if (opcode == OPC_OP_IMM) begin
         if (!shift_imm) begin
            dec.illegal = 1'b0;
            dec.rs1     = rdata1;
            dec.rs2     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            dec.funct3  = f3;
            dec.rs1_src = rs1_idx;
         end else if (f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_SR)) begin
            dec.illegal = 1'b0;
            dec.rs1     = rdata1;
            dec.rs2     = {{(XLEN-5){1'b0}}, rs2_idx};
            dec.funct3  = f3;
            dec.funct7  = (f3 == F3_SR) ? in_instr[30] : 1'b0;
            dec.rs1_src = rs1_idx;
         end
      end
   end

   // Output register next state: load on accept, drain on consume, and
   // refresh held register operands from writebacks while stalled.
   always_comb begin
      op_next    = op_reg;
      valid_next = valid_reg;
      if (accept) begin
         op_next    = dec;
         valid_next = 1'b1;
      end else if (valid_reg && out_ready) begin
         valid_next = 1'b0;
      end else if (valid_reg && wb_en && wb_addr != 5'd0) begin
         if (wb_addr == op_reg.rs1_src)
            op_next.rs1 = wb_data;
         if (op_reg.rs2_is_reg && wb_addr == op_reg.rs2_src)
            op_next.rs2 = wb_data;
      end
   end

   // Output register state; reset discards any held operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg    <= '0;
         valid_reg <= 1'b0;
      end else begin
         op_reg    <= op_next;
         valid_reg <= valid_next;
      end
   end

   assign out_valid   = valid_reg;
   assign out_rs1     = op_reg.rs1;
   assign out_rs2     = op_reg.rs2;
   assign out_funct3  = op_reg.funct3;
   assign out_funct7  = op_reg.funct7;
   assign out_rd      = op_reg.rd;
   assign out_illegal = op_reg.illegal;

endmodule
